// File: rtl/sine_rom_arb.sv
// Round-robin arbiter that lets NREQ requesters share one single-port sine ROM.
// A grant drives the ROM in the same cycle. The read data returns to the
// winner two cycles later, tagged with a one-hot rvalid.
module sine_rom_arb #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NREQ       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rom_cs,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_dout,
  output logic                       busy
);

  localparam int unsigned PTR_WIDTH = 2;

  logic [PTR_WIDTH-1:0]  ptr;
  logic [PTR_WIDTH-1:0]  win;
  logic [PTR_WIDTH-1:0]  idx;
  logic                  found;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] addr_shadow;
  logic                  s1_vld;
  logic [PTR_WIDTH-1:0]  s1_idx;

  // Round-robin search starting at ptr; the first active request wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = PTR_WIDTH'(ptr + PTR_WIDTH'(k));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A grant needs enable and no active reset, so gnt/rom_cs stay low during reset.
  always_comb begin
    grant    = found & enable & reset_n;
    gnt      = '0;
    win_addr = addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    if (grant) gnt = NREQ'(1) << win;
    rom_cs   = grant;
    rom_addr = grant ? win_addr : addr_shadow;
    busy     = grant | s1_vld | (|rvalid);
  end

  // Pointer advances past the winner. The shadow keeps the last ROM address driven.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      addr_shadow <= '0;
    end else if (grant) begin
      ptr         <= win + PTR_WIDTH'(1);
      addr_shadow <= win_addr;
    end
  end

  // Stage 1 tracks the winner while the ROM access is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
    end else begin
      s1_vld <= grant;
      s1_idx <= win;
    end
  end

  // Stage 2 captures ROM data and tags it for the winner. rdata holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else if (s1_vld) begin
      rvalid <= NREQ'(1) << s1_idx;
      rdata  <= rom_dout;
    end else begin
      rvalid <= '0;
    end
  end

endmodule

// File: doc/sine_rom_arb.md
SINE_ROM_ARB -- requirements
Module: sine_rom_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, width of the sine ROM address and of each requester address.
REQ-002 Parameter DATA_WIDTH, default 16, width of the sine ROM data word.
REQ-003 Parameter NREQ, fixed 4, number of requesters sharing one single-port cust_rom instance.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port enable  input  1  when low, no new grants are issued; in-flight reads still complete.
REQ-007 Port req  input  NREQ  per-requester read request; bit i belongs to requester i.
REQ-008 Port addr  input  NREQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port gnt  output  NREQ  one-hot, combinational; high in the cycle requester i's request is accepted.
REQ-010 Port rvalid  output  NREQ  registered, one-hot; marks rdata as valid for requester i.
REQ-011 Port rdata  output  DATA_WIDTH  registered read data, shared by all requesters.
REQ-012 Port rom_cs  output  1  ROM chip select; drives cs0.
REQ-013 Port rom_addr  output  ADDR_WIDTH  ROM address; drives addr0.
REQ-014 Port rom_dout  input  DATA_WIDTH  ROM read data; driven from dout0, valid one cycle after the address is sampled.
REQ-015 Port busy  output  1  high while any read is in flight.

Function
REQ-016 Handshake: requester i holds req[i] high and addr[i] stable until it sees gnt[i]=1; the block accepts at most one request per cycle.
REQ-017 gnt = 0 whenever enable=0 or req=0; otherwise exactly one bit of gnt is high.
REQ-018 Arbitration: round-robin; search starts at pointer ptr (2 bits) and scans ptr, ptr+1, ... modulo NREQ; the first requester with req high wins.
REQ-019 After a grant to requester w, ptr becomes (w+1) mod NREQ on the next edge; with no grant, ptr holds.
REQ-020 Fairness: a continuously requesting requester is granted within NREQ cycles while enable=1.
REQ-021 In the grant cycle T, rom_cs=1 and rom_addr=addr[w] combinationally; otherwise rom_cs=0 and rom_addr holds its previous driven value (registered shadow).
REQ-022 Pipeline stage 1: at the end of T, the block registers the winner index and a valid bit (s1_vld).
REQ-023 Pipeline stage 2: at the end of T+1, rdata <= rom_dout and rvalid <= onehot(winner) if s1_vld is set, else rvalid <= 0.
REQ-024 Latency: rvalid[w] is high for exactly one cycle, T+2; rdata is held until the next rvalid.
REQ-025 Throughput: back-to-back grants are allowed every cycle; results return in grant order with no reordering.
REQ-026 busy = s1_vld OR any rvalid bit set OR grant this cycle.
REQ-027 Addresses wrap naturally; no range checks are applied, and the full 0..2^ADDR_WIDTH-1 range is legal.
REQ-028 A deasserted req without a grant is legal (request withdrawn); the block keeps no memory of it.
REQ-029 Dropping enable mid-stream: the grant in the current cycle is suppressed; stages 1 and 2 drain normally.

Reset
REQ-030 On reset_n=0, immediately and asynchronously: ptr=0, s1_vld=0, rvalid=0, rdata=0, rom_addr shadow=0.
REQ-031 While reset_n=0, gnt=0 and rom_cs=0.
REQ-032 Reset during an in-flight read discards that read; no rvalid follows after reset release.
REQ-033 The first grant after reset release goes to the lowest-indexed requesting requester.

Verification
REQ-034 Single read: req=0001, addr0=0x20, ROM[0x20]=0x5A82 -> gnt=0001 at T; rvalid=0001 and rdata=0x5A82 at T+2.
REQ-035 All four requesting continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rvalid follows the same order 2 cycles later.
REQ-036 Requesters 1 and 3 only, ptr=2 -> grant 3 then 1 on consecutive cycles; ptr ends at 2.
REQ-037 enable=0 for 3 cycles with req=1111 -> gnt=0000 and rom_cs=0 throughout; the pending rvalid from the prior grant still appears.
REQ-038 reset_n pulsed low in cycle T+1 after a grant -> rvalid stays 0000, rdata=0, ptr=0; next grant goes to the lowest requester.
REQ-039 Address wrap: addr2=0x7F then 0x00 back-to-back -> rdata=ROM[0x7F] then ROM[0x00] on consecutive cycles, rvalid=0100 both cycles.
